// File: rtl/dumper_if.sv
// Handshake and bus bundle between the RAM read-back dumper and its environment:
// the dump request, the RAM read port and the transmitter's parallel input.
interface dumper_if #(
  parameter int unsigned addrSize = 9
);
  logic                start;
  logic [addrSize-1:0] lastAddr;
  logic                stopOnZero;
  logic [7:0]          dataIn;
  logic                txBusy;

  logic                read_rq;
  logic [addrSize-1:0] addrOut;
  logic [7:0]          dataOut;
  logic                newData;
  logic                busy;
  logic                done;
  logic [addrSize:0]   byteCount;

  // Dumper side.
  modport master (
    input  start, lastAddr, stopOnZero, dataIn, txBusy,
    output read_rq, addrOut, dataOut, newData, busy, done, byteCount
  );

  // Host / RAM / transmitter side.
  modport slave (
    output start, lastAddr, stopOnZero, dataIn, txBusy,
    input  read_rq, addrOut, dataOut, newData, busy, done, byteCount
  );
endinterface

// File: rtl/dumper.sv
// Reads program RAM from address 0 up to a latched last address and hands each
// byte to the serial transmitter, one byte per newData pulse. Optionally stops
// at the first 0x00 byte without sending it. All outputs are registered.
module dumper #(
  parameter int unsigned addrSize = 9
) (
  input logic      clk,
  input logic      reset,
  dumper_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapture,
    StSend,
    StPulse,
    StFinish
  } state_e;

  localparam logic [addrSize-1:0] AddrOne  = 1;
  localparam logic [addrSize:0]   CountOne = 1;

  state_e              state_q;
  logic [addrSize-1:0] addr_q;
  logic [addrSize-1:0] last_q;
  logic                soz_q;
  logic [7:0]          data_q;
  logic [addrSize:0]   count_q;
  logic                read_rq_q;
  logic                new_data_q;
  logic                busy_q;
  logic                done_q;

  // Dump sequencer; pulse outputs are set on entry to the state that owns them,
  // so read_rq/newData/done are high exactly while in READ/PULSE/FINISH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      last_q     <= '0;
      soz_q      <= 1'b0;
      data_q     <= '0;
      count_q    <= '0;
      read_rq_q  <= 1'b0;
      new_data_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      read_rq_q  <= 1'b0;
      new_data_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            addr_q    <= '0;
            count_q   <= '0;
            last_q    <= bus.lastAddr;
            soz_q     <= bus.stopOnZero;
            busy_q    <= 1'b1;
            read_rq_q <= 1'b1;
            state_q   <= StRead;
          end
        end
        StRead: begin
          state_q <= StCapture;
        end
        StCapture: begin
          data_q <= bus.dataIn;
          // A terminating zero is neither sent nor counted.
          if (soz_q && (bus.dataIn == 8'h00)) begin
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            state_q <= StSend;
          end
        end
        StSend: begin
          if (!bus.txBusy) begin
            new_data_q <= 1'b1;
            state_q    <= StPulse;
          end
        end
        StPulse: begin
          count_q <= count_q + CountOne;
          // Terminal compare before increment, so addrOut never wraps.
          if (addr_q == last_q) begin
            done_q  <= 1'b1;
            state_q <= StFinish;
          end else begin
            addr_q    <= addr_q + AddrOne;
            read_rq_q <= 1'b1;
            state_q   <= StRead;
          end
        end
        StFinish: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.read_rq   = read_rq_q;
  assign bus.addrOut   = addr_q;
  assign bus.dataOut   = data_q;
  assign bus.newData   = new_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.byteCount = count_q;

endmodule

// File: tb/tb_dumper.sv
// Directed bench for dumper: a 512-byte instance for most scenarios and a
// 16-byte instance for the full-RAM, no-wrap scenario. Cycle n counts clock
// periods after the edge that accepted start (cycle 1 is the first READ).
module tb_dumper;

  logic clk;
  logic reset;

  dumper_if #(.addrSize(9)) ifc ();
  dumper_if #(.addrSize(4)) ifc4 ();

  dumper #(.addrSize(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  dumper #(.addrSize(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc4)
  );

  logic [7:0] mem  [512];
  logic [7:0] mem4 [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle synchronous RAM models.
  always @(posedge clk) if (ifc.read_rq) ifc.dataIn <= mem[ifc.addrOut];
  always @(posedge clk) if (ifc4.read_rq) ifc4.dataIn <= mem4[ifc4.addrOut];

  int tests  = 0;
  int failed = 0;

  int         nd_cyc [$];
  logic [7:0] nd_dat [$];
  int         done_cyc;
  int         done_cnt;
  int         busy_low_cyc;
  int         rd_first;
  int         busy_at1;
  int         bc_at1;
  int         timed_out;
  logic [7:0] exp_dat [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a dump at the current negedge and follows it until busy drops.
  // hold > 0: transmitter holds txBusy for that many cycles after each newData.
  // spam: keep start high while busy and in the FINISH cycle.
  task automatic run_dump(input logic [8:0] last, input logic soz, input int hold,
                          input bit spam, input int max_cyc);
    int cnt;
    cnt = 0;
    nd_cyc.delete();
    nd_dat.delete();
    done_cyc = -1;
    done_cnt = 0;
    busy_low_cyc = -1;
    rd_first = -1;
    timed_out = 1;
    ifc.lastAddr = last;
    ifc.stopOnZero = soz;
    ifc.start = 1'b1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (n == 1) begin
        busy_at1 = ifc.busy;
        bc_at1 = ifc.byteCount;
        // Latched values must not follow these.
        ifc.lastAddr = ~last;
        ifc.stopOnZero = ~soz;
      end
      if (ifc.read_rq && rd_first < 0) rd_first = n;
      if (ifc.newData) begin
        nd_cyc.push_back(n);
        nd_dat.push_back(ifc.dataOut);
        if (hold > 0) cnt = hold;
      end
      if (ifc.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (cnt > 0) begin
        ifc.txBusy = 1'b1;
        cnt--;
      end else begin
        ifc.txBusy = 1'b0;
      end
      if (done_cyc >= 0 && !ifc.busy) begin
        busy_low_cyc = n;
        timed_out = 0;
        ifc.start = 1'b0;
        ifc.txBusy = 1'b0;
        break;
      end
      ifc.start = spam && (done_cyc < 0 || n == done_cyc);
    end
    ifc.start = 1'b0;
    check("timeout", timed_out, 0);
  endtask

  // Checks newData count, cycles c0 + k*step and data exp_dat[k].
  task automatic check_seq(input string tag, input int n, input int c0, input int step);
    check({tag, "_count"}, nd_cyc.size(), n);
    for (int k = 0; k < n; k++) begin
      check({tag, "_cycle"}, (k < nd_cyc.size()) ? nd_cyc[k] : -1, c0 + k * step);
      check({tag, "_data"}, (k < nd_dat.size()) ? nd_dat[k] : 8'hxx, exp_dat[k]);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {1'b0, ifc.read_rq, ifc.addrOut, ifc.dataOut, ifc.newData, ifc.busy,
            ifc.done, ifc.byteCount};
  endfunction

  initial begin
    int dc;
    int nd4;
    int bad4;
    int wrap4;
    int seen15;
    int done4;
    int to4;

    for (int i = 0; i < 512; i++) mem[i] = 8'hff;
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[3] = 8'h44;
    for (int i = 0; i < 16; i++) mem4[i] = 8'(i + 1);

    ifc.start = 0; ifc.lastAddr = 0; ifc.stopOnZero = 0; ifc.txBusy = 0;
    ifc4.start = 0; ifc4.lastAddr = 0; ifc4.stopOnZero = 0; ifc4.txBusy = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_read_rq", ifc.read_rq, 0);
    check("rst_addrOut", ifc.addrOut, 0);
    check("rst_dataOut", ifc.dataOut, 0);
    check("rst_newData", ifc.newData, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_byteCount", ifc.byteCount, 0);
    reset = 1'b1;
    @(negedge clk);

    // Four bytes, transmitter always ready.
    exp_dat[0] = 8'h41; exp_dat[1] = 8'h42; exp_dat[2] = 8'h43; exp_dat[3] = 8'h44;
    run_dump(9'd3, 1'b0, 0, 1'b0, 100);
    check("t1_busy_c1", busy_at1, 1);
    check("t1_first_rd", rd_first, 1);
    check_seq("t1", 4, 4, 4);
    check("t1_done_cyc", done_cyc, 17);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_low", busy_low_cyc, 18);
    check("t1_byteCount", ifc.byteCount, 4);
    check("t1_addrOut", ifc.addrOut, 3);

    // Transmitter busy for 10 cycles after every byte.
    run_dump(9'd3, 1'b0, 10, 1'b0, 200);
    check_seq("t3", 4, 4, 11);
    check("t3_done_cyc", done_cyc, 38);
    check("t3_byteCount", ifc.byteCount, 4);

    // Reset while waiting in SEND for byte 1 (cycle 7).
    ifc.lastAddr = 9'd3; ifc.stopOnZero = 0; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_bc", ifc.byteCount, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_send_outs", outs_vec(), 0);
    reset = 1'b1;
    dc = 0;
    repeat (5) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) dc++;
    end
    check("rst_send_quiet", dc, 0);

    // Reset in PULSE of byte 1 (cycle 8).
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_nd", ifc.newData, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_pulse_outs", outs_vec(), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_pulse_done", ifc.done, 0);

    // Fresh dump after reset restarts from address 0; start spammed throughout.
    run_dump(9'd3, 1'b0, 0, 1'b1, 100);
    check_seq("t6", 4, 4, 4);
    check("t6_done_cyc", done_cyc, 17);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_busy_low", busy_low_cyc, 18);
    check("t6_byteCount", ifc.byteCount, 4);

    // Start in the first idle cycle is accepted and clears byteCount.
    run_dump(9'd0, 1'b0, 0, 1'b0, 100);
    check("t7_busy_c1", busy_at1, 1);
    check("t7_bc_c1", bc_at1, 0);
    check_seq("t7", 1, 4, 4);
    check("t7_done_cyc", done_cyc, 5);
    check("t7_byteCount", ifc.byteCount, 1);

    // Stop on zero at address 1.
    mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'h20;
    mem[3] = 8'h30; mem[4] = 8'h40; mem[5] = 8'h50;
    exp_dat[0] = 8'h10;
    run_dump(9'd5, 1'b1, 0, 1'b0, 100);
    check_seq("t2", 1, 4, 4);
    check("t2_done_cyc", done_cyc, 7);
    check("t2_byteCount", ifc.byteCount, 1);
    check("t2_addrOut", ifc.addrOut, 1);

    // Same RAM without stop-on-zero: the zero byte is sent normally.
    exp_dat[0] = 8'h10; exp_dat[1] = 8'h00; exp_dat[2] = 8'h20;
    exp_dat[3] = 8'h30; exp_dat[4] = 8'h40; exp_dat[5] = 8'h50;
    run_dump(9'd5, 1'b0, 0, 1'b0, 100);
    check_seq("t2b", 6, 4, 4);
    check("t2b_done_cyc", done_cyc, 25);
    check("t2b_byteCount", ifc.byteCount, 6);

    // Whole 16-byte RAM on the small instance; addrOut must stop at 15.
    nd4 = 0; bad4 = 0; wrap4 = 0; seen15 = 0; done4 = -1; to4 = 1;
    ifc4.lastAddr = 4'd15; ifc4.stopOnZero = 0; ifc4.start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      ifc4.start = 1'b0;
      if (ifc4.newData) begin
        if (ifc4.dataOut != 8'(nd4 + 1)) bad4++;
        nd4++;
      end
      if (seen15 != 0 && ifc4.addrOut != 4'd15) wrap4 = 1;
      if (ifc4.addrOut == 4'd15) seen15 = 1;
      if (ifc4.done && done4 < 0) done4 = n;
      if (done4 >= 0 && !ifc4.busy) begin
        to4 = 0;
        break;
      end
    end
    check("t4_timeout", to4, 0);
    check("t4_count", nd4, 16);
    check("t4_order", bad4, 0);
    check("t4_nowrap", wrap4, 0);
    check("t4_done_cyc", done4, 65);
    check("t4_byteCount", ifc4.byteCount, 16);
    check("t4_addrOut", ifc4.addrOut, 15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dumper.md
# dumper

Reads program RAM sequentially from address 0 and emits each byte in parallel format, one byte per handshake, towards a serial transmitter. It is the read-back counterpart of the loader that fills the RAM from the parallel byte stream, and it lets the host verify or retrieve a loaded program. It sits between the RAM read port and the transmitter's parallel input.

## Interface
- addrSize, 9: RAM address width; RAM depth is 2^addrSize bytes.

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  dump request, sampled only in IDLE
- lastAddr  in  addrSize  last address to dump (inclusive), latched on accepted start
- stopOnZero  in  1  when 1, dump ends at first 0x00 byte (byte not sent); latched on accepted start
- dataIn  in  8  RAM read data, valid the cycle after read_rq
- txBusy  in  1  transmitter busy; no newData issued while high
- read_rq  out  1  RAM read strobe, one cycle per byte
- addrOut  out  addrSize  RAM read address
- dataOut  out  8  byte to transmit, stable from CAPTURE until next CAPTURE
- newData  out  1  one-cycle pulse: dataOut is valid, transmitter must take it
- busy  out  1  high from cycle after accepted start until FINISH exits
- done  out  1  one-cycle pulse at end of dump
- byteCount  out  addrSize+1  bytes sent in current/last dump; cleared on accepted start

## Operation
- States: IDLE, READ, CAPTURE, SEND, PULSE, FINISH. All outputs registered / Moore-decoded from state.
- IDLE: start=1 -> addrOut<=0, byteCount<=0, latch lastAddr/stopOnZero, busy<=1, -> READ. start=0 -> stay.
- READ: read_rq=1 with addrOut. -> CAPTURE.
- CAPTURE: dataOut<=dataIn. If stopOnZero and dataIn==0x00 -> FINISH; else -> SEND.
- SEND: txBusy=1 -> stay; txBusy=0 -> PULSE.
- PULSE: newData=1, byteCount<=byteCount+1. If addrOut==latched lastAddr -> FINISH; else addrOut<=addrOut+1, -> READ.
- FINISH: done=1, busy<=0, -> IDLE.
- start while not IDLE: ignored. Changes to lastAddr/stopOnZero mid-dump: no effect.
- addrOut never wraps: terminal compare stops at lastAddr; lastAddr=2^addrSize-1 dumps whole RAM, byteCount reaches 2^addrSize (needs the extra bit).
- Zero byte with stopOnZero=1: not sent, not counted; zero byte with stopOnZero=0: sent normally.
- Reset (reset=0) at any edge, including mid-dump: state IDLE, all outputs 0, latched values 0; in-flight byte abandoned, no done pulse.

## Timing
- Reset values: read_rq 0, addrOut 0, dataOut 0, newData 0, busy 0, done 0, byteCount 0.
- Cycle 0 = edge where start=1 sampled in IDLE. With txBusy held 0: byte k read_rq in cycle 1+4k, newData in cycle 4+4k; 4 cycles per byte.
- Last byte at address L (no early stop): newData cycle 4+4L, done cycle 5+4L, busy low from cycle 6+4L, new start accepted in cycle 6+4L.
- Early stop at address z: done in cycle 3+4z (after CAPTURE), no newData for z.
- Each txBusy cycle in SEND adds one cycle; newData asserts the cycle after txBusy first seen 0.
- Transmitter contract: raise txBusy within 2 cycles of newData (before SEND re-evaluates); newData is never held more than one cycle.
- dataIn must be valid in the cycle after read_rq (one-cycle synchronous RAM).

## Test plan
- RAM[0..3]=41,42,43,44, lastAddr=3, stopOnZero=0, txBusy=0 -> newData at cycles 4,8,12,16 with dataOut 41..44, done cycle 17, byteCount=4, busy low cycle 18.
- RAM[0..2]=10,00,20, lastAddr=5, stopOnZero=1 -> one newData (0x10) at cycle 4, done cycle 7, byteCount=1, addrOut ends 1; repeat with stopOnZero=0 -> bytes 10,00,20,... sent through address 5, byteCount=6.
- txBusy held 1 for 10 cycles after each newData -> every byte waits in SEND, newData one cycle after txBusy falls, no byte lost or duplicated, order preserved.
- addrSize=4, lastAddr=15, RAM filled with i+1 -> 16 bytes 01..10 sent, byteCount=16, addrOut stops at 15, no wrap to 0.
- reset=0 pulsed mid-dump during SEND and again during PULSE -> next cycle all outputs 0, no done pulse; subsequent start dumps from address 0 correctly.
- start pulsed repeatedly while busy=1 and in the FINISH cycle -> ignored; start in cycle after busy falls -> new dump accepted, byteCount cleared.
